retire_stage: RTL and testbench
===============================

// Module: retire_stage
// PURPOSE
// Commit stage directly downstream of the ROB; retires up to 2 in-order head entries/cycle.
// Updates the retirement RAT (architectural map) and returns each T_old to the freelist.
// Converts a retiring mispredicted branch into a 1-cycle pipeline flush.
// Converts a retiring halt into a sticky halted state. Counts committed instructions.
// PARAMETERS
// ARCH_REGS       32                       number of architectural registers (x0 hardwired)
// PREG_NUM        64                       number of physical registers
// PREG_IDX_WIDTH  $clog2(PREG_NUM)         physical tag width
// ARCH_IDX_WIDTH  $clog2(ARCH_REGS)        architectural index width
// PORTS
// clock           in   1                           single clock; all state updates on posedge
// reset           in   1                           synchronous, active-high
// rob_valid       in   2                           slot retires this cycle; slot0 = older
// rob_dest_valid  in   2                           slot writes a destination (rd != x0)
// rob_arch_dest   in   2 x ARCH_IDX_WIDTH          architectural rd per slot
// rob_T_new       in   2 x PREG_IDX_WIDTH          committed physical tag per slot
// rob_T_old       in   2 x PREG_IDX_WIDTH          previous mapping of rd per slot
// rob_halt        in   2                           slot is a halt instruction
// rob_mispredict  in   2                           slot is a resolved mispredicted branch
// retire_en       out  1                           ROB may dequeue; combinational, = (state==RUN)
// free_valid      out  2                           registered freelist return per slot
// free_preg       out  2 x PREG_IDX_WIDTH          registered T_old being freed
// rrat_map        out  ARCH_REGS x PREG_IDX_WIDTH  retirement map table
// flush           out  1                           1-cycle pipeline flush pulse
// halted          out  1                           sticky; set after halt retires
// retire_cnt      out  64                          committed instruction count
// BEHAVIOUR
// Reset (sync, active-high)
// - State = RUN; rrat_map[i] = i; free_valid = 0; free_preg = 0.
// - flush = 0; halted = 0; retire_cnt = 0.
// - Reset overrides everything, including FLUSH or HALTED in progress.
// Slot qualification (RUN only; all inputs ignored in FLUSH and HALTED)
// - s0 = rob_valid[0].
// - s1 = rob_valid[1] & rob_valid[0] & ~rob_halt[0] & ~rob_mispredict[0].
// - rob_valid[1] without rob_valid[0] is a protocol error: slot1 is ignored.
// - Slot1 behind a halt or mispredict in slot0 is discarded: not retired, not freed, not counted.
// Per qualified slot k
// - If rob_dest_valid[k] and rob_arch_dest[k] != 0: rrat_map[dest] <= T_new.
// - If rob_dest_valid[k] and rob_arch_dest[k] != 0: free_valid[k] <= 1, free_preg[k] <= T_old.
// - Otherwise free_valid[k] <= 0.
// - rrat_map[0] is never written and stays 0.
// - s0 and s1 with the same rd: slot1 value wins in rrat_map; both T_olds are freed.
// Timing and counting
// - All outputs are registered (1-cycle latency) except retire_en.
// - free_valid is deasserted every cycle without a qualifying slot.
// - retire_cnt <= retire_cnt + s0 + s1, with 64-bit wrap.
// FSM
// - RUN -> FLUSH: a qualified slot has mispredict and no halt.
//   flush = 1 during FLUSH, exactly 1 cycle; the ROB, RS and RAT clear on it.
// - FLUSH -> RUN: unconditional, next cycle.
// - RUN -> HALTED: a qualified slot has halt; halt wins over a mispredict on the same slot.
// - The halt instruction itself is retired and counted.
// - HALTED is sticky until reset: retire_en = 0, halted = 1, no further updates.
// - The mispredicting or halting instruction's own RRAT update and free still occur.
// TESTING
// T1 Reset, then idle -> rrat_map[5]=5, retire_en=1, flush=0, halted=0, retire_cnt=0.
// T2 Both slots valid: s0 rd=3 T_new=40 T_old=3; s1 rd=7 T_new=41 T_old=7
//    -> next cycle rrat[3]=40, rrat[7]=41, free_valid=2'b11, free_preg={7,3}, cnt=2.
// T3 Both slots rd=9: T_new 50/51, T_old 9/50
//    -> rrat[9]=51, free_preg={50,9}, free_valid=2'b11.
// T4 s0 mispredict rd=0, s1 valid rd=4
//    -> s1 discarded, rrat[4] unchanged, cnt+1;
//    -> flush=1 for exactly 1 cycle, retire_en=0 that cycle, then RUN.
// T5 s0 plain rd=2, s1 halt
//    -> cnt+2, halted=1 sticky, retire_en=0;
//    -> later valid inputs change nothing; reset restores RUN and identity map.
// T6 Reset asserted during the FLUSH cycle -> next cycle flush=0, state RUN, all reset values.

Source files
------------

// File: rtl/retire_stage.sv
// -----------------------------------------------------------------------------
// retire_stage
//   Commit stage directly downstream of the ROB. Retires up to two in-order
//   head entries per cycle, updates the retirement RAT, returns each retired
//   instruction's previous mapping (T_old) to the freelist, turns a retiring
//   mispredicted branch into a one-cycle flush pulse, turns a retiring halt
//   into a sticky halted state and counts committed instructions.
//
// Ports
//   clock, reset        single clock; synchronous active-high reset
//   rob_valid[1:0]      slot retires this cycle (slot0 is the older entry)
//   rob_dest_valid      slot writes a destination register
//   rob_arch_dest       architectural rd per slot
//   rob_T_new           committed physical tag per slot
//   rob_T_old           previous physical mapping of rd per slot
//   rob_halt            slot is a halt instruction
//   rob_mispredict      slot is a resolved mispredicted branch
//   retire_en           ROB may dequeue (combinational, high only in RUN)
//   free_valid          registered freelist return strobe per slot
//   free_preg           registered tag being freed per slot
//   rrat_map            retirement (architectural) map table
//   flush               one-cycle pipeline flush pulse
//   halted              sticky, set once a halt has retired
//   retire_cnt          64-bit committed instruction count (wraps)
// -----------------------------------------------------------------------------
module retire_stage #(
   parameter int ARCH_REGS      = 32,
   parameter int PREG_NUM       = 64,
   parameter int PREG_IDX_WIDTH = $clog2(PREG_NUM),
   parameter int ARCH_IDX_WIDTH = $clog2(ARCH_REGS)
) (
   input  logic                                      clock,
   input  logic                                      reset,
   input  logic [1:0]                                rob_valid,
   input  logic [1:0]                                rob_dest_valid,
   input  logic [1:0][ARCH_IDX_WIDTH-1:0]            rob_arch_dest,
   input  logic [1:0][PREG_IDX_WIDTH-1:0]            rob_T_new,
   input  logic [1:0][PREG_IDX_WIDTH-1:0]            rob_T_old,
   input  logic [1:0]                                rob_halt,
   input  logic [1:0]                                rob_mispredict,
   output logic                                      retire_en,
   output logic [1:0]                                free_valid,
   output logic [1:0][PREG_IDX_WIDTH-1:0]            free_preg,
   output logic [ARCH_REGS-1:0][PREG_IDX_WIDTH-1:0]  rrat_map,
   output logic                                      flush,
   output logic                                      halted,
   output logic [63:0]                               retire_cnt
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      FLUSH  = 2'd1,
      HALTED = 2'd2
   } state_e;

   state_e                                    state_q, state_d;
   logic [ARCH_REGS-1:0][PREG_IDX_WIDTH-1:0]  rrat_map_q, rrat_map_d;
   logic [1:0]                                free_valid_q, free_valid_d;
   logic [1:0][PREG_IDX_WIDTH-1:0]            free_preg_q, free_preg_d;
   logic                                      flush_q, flush_d;
   logic                                      halted_q, halted_d;
   logic [63:0]                               retire_cnt_q, retire_cnt_d;

   logic       run;
   logic [1:0] qual;     // slot actually retires this cycle
   logic [1:0] writes;   // qualified slot with a real (non-x0) destination
   logic       any_halt;
   logic       any_mispredict;

   // NOTE: every signal assigned in this block gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      run = (state_q == RUN);

      // Slot1 only retires behind a valid, non-redirecting slot0; a lone
      // slot1 is a protocol error and is dropped.
      qual[0] = run & rob_valid[0];
      qual[1] = run & rob_valid[1] & rob_valid[0] & ~rob_halt[0] & ~rob_mispredict[0];

      for (int k = 0; k < 2; k++) begin
         writes[k] = qual[k] & rob_dest_valid[k] & (rob_arch_dest[k] != '0);
      end

      any_halt       = |(qual & rob_halt);
      any_mispredict = |(qual & rob_mispredict);

      // Slot1 is applied after slot0 so the younger write wins on a shared rd.
      rrat_map_d = rrat_map_q;
      if (writes[0]) rrat_map_d[rob_arch_dest[0]] = rob_T_new[0];
      if (writes[1]) rrat_map_d[rob_arch_dest[1]] = rob_T_new[1];

      free_valid_d = writes;
      free_preg_d  = free_preg_q;
      for (int k = 0; k < 2; k++) begin
         if (writes[k]) free_preg_d[k] = rob_T_old[k];
      end

      retire_cnt_d = retire_cnt_q + 64'(qual[0]) + 64'(qual[1]);

      state_d = state_q;
      unique case (state_q)
         RUN: begin
            if (any_halt)            state_d = HALTED;
            else if (any_mispredict) state_d = FLUSH;
         end
         FLUSH:   state_d = RUN;
         HALTED:  state_d = HALTED;
         default: state_d = RUN;
      endcase

      flush_d  = (state_d == FLUSH);
      halted_d = (state_d == HALTED);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= RUN;
         free_valid_q <= '0;
         free_preg_q  <= '0;
         flush_q      <= 1'b0;
         halted_q     <= 1'b0;
         retire_cnt_q <= '0;
         // NOTE: the map table is architectural state and must come out of
         // reset as the identity mapping, so unlike a plain data RAM it is
         // built from resettable flops.
         for (int i = 0; i < ARCH_REGS; i++) begin
            rrat_map_q[i] <= PREG_IDX_WIDTH'(i);
         end
      end else begin
         state_q      <= state_d;
         rrat_map_q   <= rrat_map_d;
         free_valid_q <= free_valid_d;
         free_preg_q  <= free_preg_d;
         flush_q      <= flush_d;
         halted_q     <= halted_d;
         retire_cnt_q <= retire_cnt_d;
      end
   end

   assign retire_en  = (state_q == RUN);
   assign free_valid = free_valid_q;
   assign free_preg  = free_preg_q;
   assign rrat_map   = rrat_map_q;
   assign flush      = flush_q;
   assign halted     = halted_q;
   assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_retire_stage.sv
// -----------------------------------------------------------------------------
// tb_retire_stage
//   Directed scenarios followed by randomized retire bundles, all compared
//   against a program-order reference model of the commit stage.
// -----------------------------------------------------------------------------
module tb_retire_stage;

   localparam int NA = 32;
   localparam int NP = 64;
   localparam int PW = 6;
   localparam int AW = 5;

   logic                     clock = 1'b0;
   logic                     reset;
   logic [1:0]               rob_valid;
   logic [1:0]               rob_dest_valid;
   logic [1:0][AW-1:0]       rob_arch_dest;
   logic [1:0][PW-1:0]       rob_T_new;
   logic [1:0][PW-1:0]       rob_T_old;
   logic [1:0]               rob_halt;
   logic [1:0]               rob_mispredict;
   logic                     retire_en;
   logic [1:0]               free_valid;
   logic [1:0][PW-1:0]       free_preg;
   logic [NA-1:0][PW-1:0]    rrat_map;
   logic                     flush;
   logic                     halted;
   logic [63:0]              retire_cnt;

   retire_stage #(.ARCH_REGS(NA), .PREG_NUM(NP)) dut (
      .clock          (clock),
      .reset          (reset),
      .rob_valid      (rob_valid),
      .rob_dest_valid (rob_dest_valid),
      .rob_arch_dest  (rob_arch_dest),
      .rob_T_new      (rob_T_new),
      .rob_T_old      (rob_T_old),
      .rob_halt       (rob_halt),
      .rob_mispredict (rob_mispredict),
      .retire_en      (retire_en),
      .free_valid     (free_valid),
      .free_preg      (free_preg),
      .rrat_map       (rrat_map),
      .flush          (flush),
      .halted         (halted),
      .retire_cnt     (retire_cnt)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   int unsigned     m_rrat [NA];
   longint unsigned m_cnt;
   bit              m_halted;
   bit              m_flush;
   bit [1:0]        m_fv;
   int unsigned     m_fp [2];
   bit              m_was_reset;

   // Walk the bundle in program order; anything younger than a halt or a
   // mispredict (or behind an empty slot0) is squashed.
   function automatic void model_step();
      bit h, mp;
      m_was_reset = reset;
      if (reset) begin
         foreach (m_rrat[i]) m_rrat[i] = i;
         m_cnt = 0; m_halted = 0; m_flush = 0; m_fv = 0;
         m_fp[0] = 0; m_fp[1] = 0;
         return;
      end
      m_fv = 0;
      if (m_halted || m_flush) begin
         m_flush = 0;
         return;
      end
      h = 0; mp = 0;
      for (int k = 0; k < 2; k++) begin
         if (!rob_valid[k] || h || mp) break;
         m_cnt++;
         if (rob_dest_valid[k] && rob_arch_dest[k] != 0) begin
            m_rrat[rob_arch_dest[k]] = rob_T_new[k];
            m_fv[k] = 1;
            m_fp[k] = rob_T_old[k];
         end
         if (rob_halt[k]) h = 1;
         else if (rob_mispredict[k]) mp = 1;
      end
      m_halted = h;
      m_flush  = mp;
   endfunction

   task automatic compare_all();
      check("retire_en", retire_en, !(m_halted || m_flush));
      check("flush", flush, m_flush);
      check("halted", halted, m_halted);
      check("free_valid", free_valid, m_fv);
      for (int k = 0; k < 2; k++) begin
         if (m_fv[k] || m_was_reset) check($sformatf("free_preg[%0d]", k), free_preg[k], m_fp[k]);
      end
      check("retire_cnt", retire_cnt, m_cnt);
      for (int i = 0; i < NA; i++) check($sformatf("rrat[%0d]", i), rrat_map[i], m_rrat[i]);
   endtask

   task automatic step();
      @(posedge clock);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic idle();
      rob_valid = 0; rob_dest_valid = 0; rob_arch_dest = '0;
      rob_T_new = '0; rob_T_old = '0; rob_halt = 0; rob_mispredict = 0;
   endtask

   task automatic set_slot(input int k, input bit v, input bit dv, input int rd,
                           input int tn, input int to, input bit h, input bit m);
      rob_valid[k] = v; rob_dest_valid[k] = dv; rob_arch_dest[k] = AW'(rd);
      rob_T_new[k] = PW'(tn); rob_T_old[k] = PW'(to);
      rob_halt[k] = h; rob_mispredict[k] = m;
   endtask

   task automatic do_reset();
      reset = 1; idle(); step(); reset = 0;
   endtask

   initial begin
      int halted_cycles;
      reset = 1; idle();
      step(); step();
      reset = 0;

      // T1: idle after reset
      step();
      check("t1_rrat5", rrat_map[5], 5);
      check("t1_retire_en", retire_en, 1);
      check("t1_cnt", retire_cnt, 0);

      // T2: two independent destinations
      set_slot(0, 1, 1, 3, 40, 3, 0, 0);
      set_slot(1, 1, 1, 7, 41, 7, 0, 0);
      step(); idle();
      check("t2_rrat3", rrat_map[3], 40);
      check("t2_rrat7", rrat_map[7], 41);
      check("t2_free_valid", free_valid, 2'b11);
      check("t2_free_preg", free_preg, {PW'(7), PW'(3)});
      check("t2_cnt", retire_cnt, 2);
      step();
      check("t2_free_drop", free_valid, 0);

      // T3: same rd in both slots, younger wins
      set_slot(0, 1, 1, 9, 50, 9, 0, 0);
      set_slot(1, 1, 1, 9, 51, 50, 0, 0);
      step(); idle();
      check("t3_rrat9", rrat_map[9], 51);
      check("t3_free_preg", free_preg, {PW'(50), PW'(9)});

      // T4: mispredict in slot0 squashes slot1
      set_slot(0, 1, 0, 0, 0, 0, 0, 1);
      set_slot(1, 1, 1, 4, 60, 4, 0, 0);
      step(); idle();
      check("t4_flush", flush, 1);
      check("t4_retire_en", retire_en, 0);
      check("t4_rrat4", rrat_map[4], 4);
      check("t4_cnt", retire_cnt, 5);
      set_slot(0, 1, 1, 11, 33, 11, 0, 0);   // ignored while flushing
      step(); idle();
      check("t4_flush_end", flush, 0);
      check("t4_rrat11", rrat_map[11], 11);

      // T5: halt in slot1 after a plain slot0
      set_slot(0, 1, 1, 2, 20, 2, 0, 0);
      set_slot(1, 1, 0, 0, 0, 0, 1, 0);
      step();
      check("t5_halted", halted, 1);
      check("t5_cnt", retire_cnt, 7);
      set_slot(0, 1, 1, 12, 44, 12, 0, 0);
      set_slot(1, 1, 1, 13, 45, 13, 0, 0);
      for (int i = 0; i < 4; i++) step();
      check("t5_rrat12", rrat_map[12], 12);
      idle();
      do_reset();
      check("t5_rrat2", rrat_map[2], 2);

      // T6: reset during the flush cycle
      set_slot(1, 1, 1, 6, 30, 6, 0, 1);
      set_slot(0, 1, 1, 5, 31, 5, 0, 0);
      step(); idle();
      check("t6_flush", flush, 1);
      do_reset();
      check("t6_flush_cleared", flush, 0);
      check("t6_rrat5", rrat_map[5], 5);

      // Randomized bundles
      halted_cycles = 0;
      for (int c = 0; c < 3000; c++) begin
         reset = ($urandom_range(0, 149) == 0) || (halted_cycles > 6);
         for (int k = 0; k < 2; k++) begin
            rob_valid[k]      = ($urandom_range(0, 3) != 0);
            rob_dest_valid[k] = ($urandom_range(0, 4) != 0);
            rob_arch_dest[k]  = ($urandom_range(0, 5) == 0) ? AW'(0) : AW'($urandom_range(0, NA - 1));
            rob_T_new[k]      = PW'($urandom_range(0, NP - 1));
            rob_T_old[k]      = PW'($urandom_range(0, NP - 1));
            rob_halt[k]       = ($urandom_range(0, 39) == 0);
            rob_mispredict[k] = ($urandom_range(0, 9) == 0);
         end
         step();
         halted_cycles = m_halted ? halted_cycles + 1 : 0;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
